// File: rtl/alu_result_stage.sv
// ALU result stage: small FIFO between ALU and memory stage that commits flags into the CCR.
// Optional macro CCR_SHADOW_EN adds a save/restore shadow copy of the CCR.
module alu_result_stage #(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_result,
  input  logic         in_carry,
  input  logic         in_zero,
  input  logic         in_neg,
  input  logic [3:0]   in_op,
  input  logic [2:0]   in_fmask,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [3:0]   out_op,
  output logic [2:0]   out_flags,
  input  logic         flush,
  output logic [2:0]   ccr,
  input  logic         ccr_save,
  input  logic         ccr_restore,
  output logic [15:0]  retired
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;

  logic [W-1:0] res_mem [DEPTH];
  logic [3:0]   op_mem  [DEPTH];
  logic [2:0]   flg_mem [DEPTH];
  logic [2:0]   msk_mem [DEPTH];

  ptr_t          wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    ccr_q, ccr_d;
  logic [15:0]   ret_q, ret_d;
  logic          acc, cmt;

`ifdef CCR_SHADOW_EN
  logic [2:0] shd_q, shd_d;
`else
  logic unused_shadow_ctl;
  assign unused_shadow_ctl = ccr_save ^ ccr_restore;
`endif

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Readiness comes only from registered occupancy, never from out_ready.
  assign in_ready   = (cnt_q < CW'(DEPTH));
  assign out_valid  = (cnt_q != '0);
  assign acc        = in_valid && in_ready;
  assign cmt        = out_valid && out_ready;

  assign out_result = res_mem[rp_q];
  assign out_op     = op_mem[rp_q];
  assign out_flags  = flg_mem[rp_q];
  assign ccr        = ccr_q;
  assign retired    = ret_q;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    ccr_d = ccr_q;
    ret_d = ret_q;
`ifdef CCR_SHADOW_EN
    shd_d = shd_q;
`endif
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (acc) wp_d = ptr_inc(wp_q);
      if (cmt) begin
        rp_d  = ptr_inc(rp_q);
        ret_d = ret_q + 16'd1;
        ccr_d = (ccr_q & ~msk_mem[rp_q]) | (flg_mem[rp_q] & msk_mem[rp_q]);
      end
      case ({acc, cmt})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
`ifdef CCR_SHADOW_EN
    // Restore beats any commit update; save is suppressed when both are asserted.
    if (ccr_restore)   ccr_d = shd_q;
    else if (ccr_save) shd_d = ccr_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ccr_q <= '0;
      ret_q <= '0;
`ifdef CCR_SHADOW_EN
      shd_q <= '0;
`endif
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ccr_q <= ccr_d;
      ret_q <= ret_d;
`ifdef CCR_SHADOW_EN
      shd_q <= shd_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (acc && !flush) begin
      res_mem[wp_q] <= in_result;
      op_mem[wp_q]  <= in_op;
      flg_mem[wp_q] <= {in_carry, in_zero, in_neg};
      msk_mem[wp_q] <= in_fmask;
    end
  end
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage; expectations are hand-computed constants.
// Shadow-CCR expectations follow the CCR_SHADOW_EN macro.
module tb_alu_result_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] in_result;
  logic        in_carry, in_zero, in_neg;
  logic [3:0]  in_op;
  logic [2:0]  in_fmask;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_op;
  logic [2:0]  out_flags;
  logic        flush;
  logic [2:0]  ccr;
  logic        ccr_save, ccr_restore;
  logic [15:0] retired;

  int total = 0;
  int bad   = 0;

  alu_result_stage #(.W(16), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_carry(in_carry), .in_zero(in_zero), .in_neg(in_neg),
    .in_op(in_op), .in_fmask(in_fmask),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_op(out_op), .out_flags(out_flags),
    .flush(flush), .ccr(ccr), .ccr_save(ccr_save), .ccr_restore(ccr_restore),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [15:0] r, input logic [3:0] op,
                     input logic [2:0] f, input logic [2:0] m);
    in_valid  = 1'b1;
    in_result = r;
    in_op     = op;
    {in_carry, in_zero, in_neg} = f;
    in_fmask  = m;
  endtask

  initial begin
    logic        c;
    logic [15:0] exp_ret;
    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_op = '0;
    {in_carry, in_zero, in_neg} = 3'b000; in_fmask = '0;
    out_ready = 1'b0; flush = 1'b0; ccr_save = 1'b0; ccr_restore = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ccr", ccr, 0);
    chk("rst_retired", retired, 0);
    cyc(); cyc();
    rst_n = 1'b1;

    // Single result, one-cycle latency
    out_ready = 1'b1;
    put(16'h0006, 4'd0, 3'b000, 3'b111);
    cyc();
    in_valid = 1'b0;
    chk("lat_out_valid", out_valid, 1);
    chk("lat_out_result", out_result, 16'h0006);
    chk("lat_retired_pre", retired, 0);
    cyc();
    chk("lat_ccr", ccr, 3'b000);
    chk("lat_retired", retired, 1);
    chk("lat_empty", out_valid, 0);

    // Masked flag commit: Z then N
    put(16'h0000, 4'd1, 3'b010, 3'b010);
    cyc();
    chk("acc_no_ccr", ccr, 3'b000);
    put(16'hFFFF, 4'd2, 3'b001, 3'b001);
    cyc();
    in_valid = 1'b0;
    chk("flag1_ccr", ccr, 3'b010);
    chk("flag1_head", out_result, 16'hFFFF);
    chk("flag1_op", out_op, 4'd2);
    cyc();
    chk("flag2_ccr", ccr, 3'b011);
    chk("flag2_retired", retired, 3);

    // Backpressure and in-order drain
    out_ready = 1'b0;
    put(16'h0011, 4'd3, 3'b111, 3'b000);
    cyc();
    chk("bp_ready1", in_ready, 1);
    put(16'h0022, 4'd4, 3'b111, 3'b000);
    cyc();
    chk("bp_full", in_ready, 0);
    put(16'h0033, 4'd5, 3'b111, 3'b000);
    cyc();
    chk("bp_held_ready", in_ready, 0);
    chk("bp_stable_res", out_result, 16'h0011);
    chk("bp_stable_op", out_op, 4'd3);
    chk("bp_stable_flags", out_flags, 3'b111);
    out_ready = 1'b1;
    cyc();
    chk("drain1_res", out_result, 16'h0022);
    chk("drain1_ready", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    chk("drain2_res", out_result, 16'h0033);
    chk("drain2_op", out_op, 4'd5);
    cyc();
    chk("drain_empty", out_valid, 0);
    chk("drain_retired", retired, 6);
    chk("drain_ccr", ccr, 3'b011);

    // Flush with 2 entries, ccr = 000
    put(16'h0000, 4'd0, 3'b000, 3'b111);
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("pre_flush_ccr", ccr, 3'b000);
    out_ready = 1'b0;
    put(16'h0AAA, 4'd6, 3'b111, 3'b111);
    cyc();
    put(16'h0BBB, 4'd7, 3'b111, 3'b111);
    cyc();
    chk("pre_flush_full", in_ready, 0);
    flush = 1'b1; out_ready = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_empty", out_valid, 0);
    chk("flush_ccr", ccr, 3'b000);
    chk("flush_retired", retired, 7);
    chk("flush_ready", in_ready, 1);
    put(16'h0CCC, 4'd8, 3'b111, 3'b111);
    flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_drop_acc", out_valid, 0);

    // Shadow CCR save/restore
    out_ready = 1'b1;
    put(16'h0101, 4'd9, 3'b101, 3'b111);
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("shd_set_ccr", ccr, 3'b101);
    ccr_save = 1'b1;
    cyc();
    ccr_save = 1'b0;
    put(16'h0202, 4'd10, 3'b010, 3'b010);
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("shd_z_commit", ccr, 3'b111);
    ccr_restore = 1'b1;
    cyc();
    ccr_restore = 1'b0;
`ifdef CCR_SHADOW_EN
    chk("shd_restore", ccr, 3'b101);
`else
    chk("shd_ignored", ccr, 3'b111);
`endif
    put(16'h0303, 4'd11, 3'b000, 3'b111);
    cyc();
    in_valid = 1'b0;
    ccr_restore = 1'b1;
    cyc();
    ccr_restore = 1'b0;
`ifdef CCR_SHADOW_EN
    chk("shd_restore_prio", ccr, 3'b101);
`else
    chk("shd_commit_only", ccr, 3'b000);
`endif
    chk("shd_retired", retired, 10);

    // Reset mid-transfer
    out_ready = 1'b0;
    put(16'h0404, 4'd12, 3'b111, 3'b111);
    cyc();
    in_valid = 1'b0;
    chk("mid_held", out_valid, 1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_ccr", ccr, 3'b000);
    chk("mid_rst_retired", retired, 0);
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc();
    chk("mid_post_valid", out_valid, 0);

    // Retired counter wrap via continuous streaming
    exp_ret = 16'h0000;
    put(16'h5555, 4'd13, 3'b000, 3'b000);
    for (int i = 0; i < 70000 && exp_ret != 16'hFFFF; i++) begin
      c = out_valid && out_ready;
      cyc();
      if (c) exp_ret = exp_ret + 16'd1;
    end
    chk("wrap_max", retired, 16'hFFFF);
    cyc();
    chk("wrap_zero", retired, 16'h0000);
    in_valid = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("wrap_flush_ret", retired, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
